lifo_stack_param: RTL and testbench
===================================

// Module: lifo_stack_param
// PURPOSE
//  Parametrised pointer-based LIFO stack; supersedes the shift-register stack.
//  Adds: arbitrary depth, occupancy count, almost-full flag, push+pop replace,
//  synchronous flush, separate sticky overflow/underflow flags with clear.
//  Sits between a producer and consumer in the memory/stack subsystem; zero is a legal data value.
// PARAMETERS
//  DATA_WIDTH  8  width of each stack entry
//  STACK_SIZE  4  number of entries; >= 2, any value (not restricted to a power of 2)
//  AF_LEVEL    3  almost_full asserts when count >= AF_LEVEL; 1..STACK_SIZE
//  CW          $clog2(STACK_SIZE+1)  localparam, width of count
// PORTS
//  clk          in   1           clock, all state updates on posedge
//  reset        in   1           asynchronous, active-low; resets all state
//  push         in   1           write write_data onto top
//  pop          in   1           remove top; value presented on read_data next cycle
//  flush        in   1           synchronous clear of stack contents (count->0)
//  err_clr      in   1           synchronous clear of sticky error flags
//  write_data   in   DATA_WIDTH  data to push
//  read_data    out  DATA_WIDTH  registered popped data; holds between pops
//  top_data     out  DATA_WIDTH  combinational peek of current top; 0 when empty
//  count        out  CW          current occupancy 0..STACK_SIZE
//  full, empty  out  1           count==STACK_SIZE / count==0 (decoded from count)
//  almost_full  out  1           count >= AF_LEVEL
//  overflow     out  1           sticky: push rejected because full (no pop)
//  underflow    out  1           sticky: pop rejected because empty
//  rd_valid     out  1           1-cycle pulse, read_data updated this cycle
// BEHAVIOUR
//  Reset (reset==0, async): count=0, read_data=0, rd_valid=0, overflow=0, underflow=0;
//   memory contents are don't-care (not cleared). Reset mid-operation aborts the op.
//  Storage: mem[0..STACK_SIZE-1], sp=count; top = mem[count-1].
//  Priority per cycle: flush > push/pop. flush: count<=0, rd_valid<=0; push/pop ignored, no errors.
//  push only: if !full -> mem[count]<=write_data, count+1; else overflow<=1, no state change.
//  pop only: if !empty -> read_data<=mem[count-1], rd_valid<=1, count-1;
//   else underflow<=1, read_data unchanged, rd_valid<=0.
//  push & pop, !empty (incl. full): replace -> read_data<=old top, rd_valid<=1,
//   mem[count-1]<=write_data, count unchanged, no error.
//  push & pop, empty: treated as push only (count 0->1) and underflow<=1, rd_valid<=0.
//  Latency: push visible on top_data/count next cycle; pop data on read_data next cycle.
//  err_clr: clears overflow/underflow; an error raised in the same cycle wins (flag set).
//  Flags derive from registered count; no flag glitches; count never wraps.
// STRUCTURE
//  Shared header lifo_defs.vh: clog2 function, error-flag bit positions for status readout.
//  One sub-module: lifo_ram (sync write, async read, DATA_WIDTH x STACK_SIZE, no reset).
//  Top holds count register, op decode, read_data/rd_valid and sticky flag registers.
// TESTING  (DATA_WIDTH=8, STACK_SIZE=4, AF_LEVEL=3)
//  1 reset low mid-stream -> count=0, empty=1, read_data=0, overflow=underflow=0 immediately.
//  2 push 0x11,0x22,0x33,0x44 -> count 4, full=1, almost_full from count 3; push 0x55 -> overflow=1, top 0x44.
//  3 pop x4 from (2) -> read_data 0x44,0x33,0x22,0x11 with rd_valid each; 5th pop -> underflow=1, read_data stays 0x11.
//  4 full stack, push&pop with 0x99 -> read_data=0x44, top_data=0x99, count=4, no overflow.
//  5 empty, push&pop 0x00 -> count=1, top_data=0x00, empty=0, underflow=1; then err_clr -> flags 0.
//  6 push 3 values then flush with push=1 -> count=0, empty=1, no error; push 0x00 then pop -> read_data=0x00.

Source files
------------

// File: rtl/lifo_stack_param_pkg.sv
// lifo_stack_param_pkg: shared operation encoding, status bit positions and width helper
package lifo_stack_param_pkg;

    typedef enum logic [2:0] {
        OP_IDLE,
        OP_PUSH,
        OP_POP,
        OP_REPL,
        OP_FLUSH
    } op_e;

    localparam int ERR_OVF_BIT = 0;
    localparam int ERR_UNF_BIT = 1;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/lifo_stack_param_if.sv
// lifo_stack_param_if: producer/consumer bus of the LIFO stack
interface lifo_stack_param_if
    import lifo_stack_param_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int STACK_SIZE = 4
);
    localparam int CW = cnt_width(STACK_SIZE);

    logic                  i_push;
    logic                  i_pop;
    logic                  i_flush;
    logic                  i_err_clr;
    logic [DATA_WIDTH-1:0] i_write_data;
    logic [DATA_WIDTH-1:0] o_read_data;
    logic [DATA_WIDTH-1:0] o_top_data;
    logic [CW-1:0]         o_count;
    logic                  o_full;
    logic                  o_empty;
    logic                  o_almost_full;
    logic                  o_overflow;
    logic                  o_underflow;
    logic                  o_rd_valid;

    modport master (
        output i_push, i_pop, i_flush, i_err_clr, i_write_data,
        input  o_read_data, o_top_data, o_count, o_full, o_empty,
               o_almost_full, o_overflow, o_underflow, o_rd_valid
    );

    modport slave (
        input  i_push, i_pop, i_flush, i_err_clr, i_write_data,
        output o_read_data, o_top_data, o_count, o_full, o_empty,
               o_almost_full, o_overflow, o_underflow, o_rd_valid
    );

endinterface

// File: rtl/lifo_stack_param_ram.sv
// lifo_stack_param_ram: stack storage, synchronous write, asynchronous read, no reset
module lifo_stack_param_ram #(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);
    logic [DW-1:0] r_mem [DEPTH];

    // Contents are left uninitialised; occupancy tracking makes stale entries invisible
    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/lifo_stack_param.sv
// lifo_stack_param: pointer-based LIFO with occupancy, almost-full, replace, flush and sticky errors
module lifo_stack_param
    import lifo_stack_param_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int STACK_SIZE = 4,
    parameter int AF_LEVEL   = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    lifo_stack_param_if.slave     bus
);
    localparam int CW = cnt_width(STACK_SIZE);
    localparam int AW = $clog2(STACK_SIZE);

    logic [CW-1:0]         r_count;
    logic [CW-1:0]         w_count_nxt;
    logic [DATA_WIDTH-1:0] r_read_data;
    logic [DATA_WIDTH-1:0] w_top_raw;
    logic                  r_rd_valid;
    logic                  w_rd_fire;
    logic [1:0]            r_err;
    logic [1:0]            w_err_set;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_we;
    logic [AW-1:0]         w_waddr;
    logic [AW-1:0]         w_raddr;
    op_e                   w_op;

    assign w_full  = r_count == CW'(STACK_SIZE);
    assign w_empty = r_count == '0;
    assign w_raddr = w_empty ? '0 : AW'(r_count - CW'(1));

    // Classify the cycle; flush dominates and push+pop on an empty stack degrades to a push
    always_comb begin
        w_op = OP_IDLE;
        if (bus.i_flush)                                 w_op = OP_FLUSH;
        else if (bus.i_push && bus.i_pop && !w_empty)    w_op = OP_REPL;
        else if (bus.i_push)                             w_op = OP_PUSH;
        else if (bus.i_pop)                              w_op = OP_POP;
    end

    // Memory write, next occupancy, pop strobe and error events for the classified operation
    always_comb begin
        w_we        = 1'b0;
        w_waddr     = AW'(r_count);
        w_count_nxt = r_count;
        w_rd_fire   = 1'b0;
        w_err_set   = '0;
        case (w_op)
            OP_FLUSH: w_count_nxt = '0;
            OP_REPL: begin
                w_we      = 1'b1;
                w_waddr   = w_raddr;
                w_rd_fire = 1'b1;
            end
            OP_PUSH: begin
                w_we                   = !w_full;
                w_err_set[ERR_OVF_BIT] = w_full;
                w_err_set[ERR_UNF_BIT] = bus.i_pop;
                if (!w_full) w_count_nxt = r_count + CW'(1);
            end
            OP_POP: begin
                w_rd_fire              = !w_empty;
                w_err_set[ERR_UNF_BIT] = w_empty;
                if (!w_empty) w_count_nxt = r_count - CW'(1);
            end
            default: ;
        endcase
    end

    // Occupancy, popped-data register and sticky error flags; a new error beats err_clr
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count     <= '0;
            r_read_data <= '0;
            r_rd_valid  <= 1'b0;
            r_err       <= '0;
        end else begin
            r_count    <= w_count_nxt;
            r_rd_valid <= w_rd_fire;
            if (w_rd_fire) r_read_data <= w_top_raw;
            r_err      <= w_err_set | (r_err & {2{!bus.i_err_clr}});
        end
    end

    lifo_stack_param_ram #(
        .DW    (DATA_WIDTH),
        .DEPTH (STACK_SIZE),
        .AW    (AW)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (bus.i_write_data),
        .i_raddr (w_raddr),
        .o_rdata (w_top_raw)
    );

    assign bus.o_read_data   = r_read_data;
    assign bus.o_top_data    = w_empty ? '0 : w_top_raw;
    assign bus.o_count       = r_count;
    assign bus.o_full        = w_full;
    assign bus.o_empty       = w_empty;
    assign bus.o_almost_full = r_count >= CW'(AF_LEVEL);
    assign bus.o_overflow    = r_err[ERR_OVF_BIT];
    assign bus.o_underflow   = r_err[ERR_UNF_BIT];
    assign bus.o_rd_valid    = r_rd_valid;

endmodule

// File: tb/tb_lifo_stack_param.sv
// tb_lifo_stack_param: queue-model scoreboard bench with directed and random stimulus
module tb_lifo_stack_param;
    localparam int DW = 8;
    localparam int SS = 4;
    localparam int AF = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lifo_stack_param_if #(.DATA_WIDTH(DW), .STACK_SIZE(SS)) bus ();

    lifo_stack_param #(.DATA_WIDTH(DW), .STACK_SIZE(SS), .AF_LEVEL(AF)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int            n_vec = 0;
    int            n_bad = 0;
    logic [DW-1:0] stk[$];
    logic [DW-1:0] exp_q[$];
    bit            m_ovf = 0;
    bit            m_unf = 0;
    bit            m_valid = 0;
    logic [DW-1:0] m_rd = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every rd_valid pulse must match the oldest expected pop
    always @(posedge clk) begin
        #1;
        if (rst_n && bus.o_rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL rd_valid_unexpected: got read_data 0x%0h expected no pop", bus.o_read_data);
            end else begin
                chk("read_data_pop", {24'h0, bus.o_read_data}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic check_state();
        int n;
        n = stk.size();
        chk("count", 32'(bus.o_count), n);
        chk("empty", 32'(bus.o_empty), 32'(n == 0));
        chk("full", 32'(bus.o_full), 32'(n == SS));
        chk("almost_full", 32'(bus.o_almost_full), 32'(n >= AF));
        chk("top_data", 32'(bus.o_top_data), n > 0 ? 32'(stk[n-1]) : 32'h0);
        chk("read_data_hold", 32'(bus.o_read_data), 32'(m_rd));
        chk("overflow", 32'(bus.o_overflow), 32'(m_ovf));
        chk("underflow", 32'(bus.o_underflow), 32'(m_unf));
        chk("rd_valid", 32'(bus.o_rd_valid), 32'(m_valid));
    endtask

    task automatic model_reset();
        stk.delete();
        exp_q.delete();
        m_ovf   = 0;
        m_unf   = 0;
        m_valid = 0;
        m_rd    = '0;
    endtask

    task automatic cyc(input bit pu, input bit po, input bit fl, input bit cl, input logic [DW-1:0] d);
        bit n_ovf;
        bit n_unf;
        n_ovf = 0;
        n_unf = 0;
        bus.i_push       = pu;
        bus.i_pop        = po;
        bus.i_flush      = fl;
        bus.i_err_clr    = cl;
        bus.i_write_data = d;
        m_valid = 0;
        if (fl) begin
            stk.delete();
        end else if (pu && po && stk.size() > 0) begin
            m_rd = stk[stk.size()-1];
            exp_q.push_back(m_rd);
            stk[stk.size()-1] = d;
            m_valid = 1;
        end else if (pu) begin
            if (po) n_unf = 1;
            if (stk.size() < SS) stk.push_back(d);
            else n_ovf = 1;
        end else if (po) begin
            if (stk.size() == 0) n_unf = 1;
            else begin
                m_rd = stk.pop_back();
                exp_q.push_back(m_rd);
                m_valid = 1;
            end
        end
        m_ovf = n_ovf | (m_ovf & !cl);
        m_unf = n_unf | (m_unf & !cl);
        @(posedge clk);
        #2;
        check_state();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_state();
        @(negedge clk);
        @(negedge clk);
        check_state();
        rst_n = 1'b1;
    endtask

    initial begin
        bit bias;
        int r;
        bus.i_push       = 0;
        bus.i_pop        = 0;
        bus.i_flush      = 0;
        bus.i_err_clr    = 0;
        bus.i_write_data = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_state();
        rst_n = 1'b1;

        cyc(1, 0, 0, 0, 8'h11);
        cyc(1, 0, 0, 0, 8'h22);
        cyc(1, 0, 0, 0, 8'h33);
        chk("t2_af_at_3", 32'(bus.o_almost_full), 1);
        cyc(1, 0, 0, 0, 8'h44);
        chk("t2_full", 32'(bus.o_full), 1);
        cyc(1, 0, 0, 0, 8'h55);
        chk("t2_overflow", 32'(bus.o_overflow), 1);
        chk("t2_top", 32'(bus.o_top_data), 32'h44);

        cyc(0, 1, 0, 1, 8'h00);
        chk("t3_pop1", 32'(bus.o_read_data), 32'h44);
        cyc(0, 1, 0, 0, 8'h00);
        cyc(0, 1, 0, 0, 8'h00);
        cyc(0, 1, 0, 0, 8'h00);
        chk("t3_pop4", 32'(bus.o_read_data), 32'h11);
        cyc(0, 1, 0, 0, 8'h00);
        chk("t3_underflow", 32'(bus.o_underflow), 1);
        chk("t3_rd_hold", 32'(bus.o_read_data), 32'h11);

        cyc(1, 0, 0, 0, 8'hA5);
        cyc(1, 0, 0, 0, 8'h5A);
        do_reset();

        cyc(1, 0, 0, 0, 8'h11);
        cyc(1, 0, 0, 0, 8'h22);
        cyc(1, 0, 0, 0, 8'h33);
        cyc(1, 0, 0, 0, 8'h44);
        cyc(1, 1, 0, 0, 8'h99);
        chk("t4_read", 32'(bus.o_read_data), 32'h44);
        chk("t4_top", 32'(bus.o_top_data), 32'h99);
        chk("t4_count", 32'(bus.o_count), 4);

        cyc(0, 0, 1, 0, 8'h00);
        cyc(1, 1, 0, 0, 8'h00);
        chk("t5_count", 32'(bus.o_count), 1);
        chk("t5_underflow", 32'(bus.o_underflow), 1);
        cyc(0, 0, 0, 1, 8'h00);
        chk("t5_cleared", {30'h0, bus.o_overflow, bus.o_underflow}, 0);
        cyc(0, 1, 1, 0, 8'h00);

        cyc(1, 0, 0, 0, 8'h01);
        cyc(1, 0, 0, 0, 8'h02);
        cyc(1, 0, 0, 0, 8'h03);
        cyc(1, 0, 1, 0, 8'h04);
        chk("t6_flush_empty", 32'(bus.o_empty), 1);
        cyc(1, 0, 0, 0, 8'h00);
        cyc(0, 1, 0, 0, 8'h00);
        chk("t6_zero_pop", 32'(bus.o_read_data), 0);

        bias = 1;
        for (int i = 0; i < 800; i++) begin
            if (i % 40 == 0) bias = ~bias;
            r = $urandom_range(0, 99);
            if (r == 0) do_reset();
            else cyc($urandom_range(0, 99) < (bias ? 70 : 30),
                     $urandom_range(0, 99) < (bias ? 30 : 70),
                     $urandom_range(0, 99) < 3,
                     $urandom_range(0, 99) < 10,
                     $urandom_range(0, 3) == 0 ? 8'h00 : 8'($urandom_range(0, 255)));
        end

        cyc(0, 0, 0, 0, 8'h00);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
